// File: rtl/imgpre_process.sv
// imgpre_process: streaming RGB888 -> 8-bit luma -> 3x3 Gaussian smoother.
// Two line buffers supply the two previous lines of luma. The window is
// emitted with a fixed latency. Border pixels are suppressed by col/row
// gating, so line-buffer contents are never trusted before they are written.
module imgpre_process #(
  parameter int MAX_WIDTH = 2048,
  parameter int PIPE_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_valid,
  input  logic [7:0]  r_data,
  input  logic [7:0]  g_data,
  input  logic [7:0]  b_data,
  input  logic [11:0] img_width,
  output logic        dout_valid,
  output logic [7:0]  proc_data
);
  localparam int AW = $clog2(MAX_WIDTH);

  logic [11:0]         col;
  logic [11:0]         col_last;
  logic [1:0]          row;
  logic                win_ok;
  logic [15:0]         gray_mac;
  logic [7:0]          gray_c;

  logic                pix_v1;
  logic [7:0]          gray1;
  logic [AW-1:0]       addr1;
  logic [PIPE_LAT-1:0] tag;

  logic [7:0]          lb0 [MAX_WIDTH];
  logic [7:0]          lb1 [MAX_WIDTH];
  logic [7:0]          lb0_rd;
  logic [7:0]          lb1_rd;

  // Index 0 is the newest column; t = line row-2, m = row-1, b = current line.
  logic [2:0][7:0]     win_t;
  logic [2:0][7:0]     win_m;
  logic [2:0][7:0]     win_b;
  logic [2:0][9:0]     col_sum_c;
  logic [2:0][9:0]     col_sum;
  logic [11:0]         win_sum;

  // A width below 1 would never wrap, so treat 0 like 1.
  assign col_last = (img_width == 12'd0) ? 12'd0 : img_width - 12'd1;
  assign win_ok   = (row == 2'd2) && (col >= 12'd2);
  assign gray_mac = 16'd77  * {8'd0, r_data}
                  + 16'd150 * {8'd0, g_data}
                  + 16'd29  * {8'd0, b_data};
  assign gray_c   = 8'(gray_mac >> 8);
  assign lb0_rd   = lb0[addr1];
  assign lb1_rd   = lb1[addr1];

  // Column/row position of the next accepted pixel; row saturates at 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (din_valid) begin
      if (col >= col_last) begin
        col <= '0;
        if (row != 2'd2) row <= row + 2'd1;
      end else begin
        col <= col + 12'd1;
      end
    end
  end

  // Stage 1: register luma and its column address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_v1 <= 1'b0;
      gray1  <= '0;
      addr1  <= '0;
    end else begin
      pix_v1 <= din_valid;
      if (din_valid) begin
        gray1 <= gray_c;
        addr1 <= col[AW-1:0];
      end
    end
  end

  // Window-valid tag travels alongside the datapath, one bit per stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag <= '0;
    else        tag <= {tag[PIPE_LAT-2:0], din_valid & win_ok};
  end

  // Line buffers: lb1 holds line row-1, lb0 holds line row-2 (no reset needed).
  always_ff @(posedge clk) begin
    if (pix_v1) begin
      lb1[addr1] <= gray1;
      lb0[addr1] <= lb1_rd;
    end
  end

  // Stage 2: shift the 3x3 window by one column per valid pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_t <= '0;
      win_m <= '0;
      win_b <= '0;
    end else if (pix_v1) begin
      win_t <= {win_t[1:0], lb0_rd};
      win_m <= {win_m[1:0], lb1_rd};
      win_b <= {win_b[1:0], gray1};
    end
  end

  // Vertical 1-2-1 weighting per column.
  always_comb begin
    col_sum_c = '0;
    for (int k = 0; k < 3; k++) begin
      col_sum_c[k] = {2'b00, win_t[k]} + {1'b0, win_m[k], 1'b0} + {2'b00, win_b[k]};
    end
  end

  // Stages 3 and 4: register column sums, then the horizontal 1-2-1 total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sum <= '0;
      win_sum <= '0;
    end else begin
      col_sum <= col_sum_c;
      win_sum <= {2'b00, col_sum[0]} + {1'b0, col_sum[1], 1'b0} + {2'b00, col_sum[2]};
    end
  end

  // Output register: data holds between valid windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      proc_data  <= '0;
    end else begin
      dout_valid <= tag[PIPE_LAT-1];
      if (tag[PIPE_LAT-1]) proc_data <= 8'(win_sum >> 4);
    end
  end

endmodule

// File: tb/tb_imgpre_process.sv
// tb_imgpre_process: scenario tasks against a line-array reference model.
module tb_imgpre_process;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  r_data = '0;
  logic [7:0]  g_data = '0;
  logic [7:0]  b_data = '0;
  logic [11:0] img_width = 12'd640;
  logic        dout_valid;
  logic [7:0]  proc_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got_v[$];
  int         got_c[$];
  logic [7:0] exp_v[$];
  int         exp_c[$];

  // Reference image memory: last three lines of luma.
  logic [7:0] m_l0  [2048];
  logic [7:0] m_l1  [2048];
  logic [7:0] m_cur [2048];
  int m_row = 0;
  int m_col = 0;

  imgpre_process dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .img_width(img_width), .dout_valid(dout_valid), .proc_data(proc_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every output with the cycle it appeared on.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1) begin
      got_v.push_back(proc_data);
      got_c.push_back(cyc);
    end
  end

  function automatic int weight(input int dy, input int dx);
    return ((dy == 1) ? 2 : 1) * ((dx == 1) ? 2 : 1);
  endfunction

  // Model one accepted pixel sampled on edge number 'at'.
  task automatic model_accept(input int r, input int g, input int b, input int at);
    int gray, s, w, px;
    w = int'(img_width);
    if (w < 1) w = 1;
    gray = (77 * r + 150 * g + 29 * b) / 256;
    m_cur[m_col] = 8'(gray);
    if (m_row >= 2 && m_col >= 2) begin
      s = 0;
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++) begin
          px = (dy == 0) ? int'(m_l0[m_col-2+dx]) :
               (dy == 1) ? int'(m_l1[m_col-2+dx]) : int'(m_cur[m_col-2+dx]);
          s += weight(dy, dx) * px;
        end
      exp_v.push_back(8'(s / 16));
      exp_c.push_back(at + 4);
    end
    m_col++;
    if (m_col >= w) begin
      m_col = 0;
      if (m_row < 2) m_row++;
      m_l0 = m_l1;
      m_l1 = m_cur;
    end
  endtask

  task automatic put_px(input int r, input int g, input int b);
    din_valid = 1'b1;
    r_data = 8'(r); g_data = 8'(g); b_data = 8'(b);
    @(posedge clk); #1;
    model_accept(r, g, b, cyc);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    r_data = 8'($urandom); g_data = 8'($urandom); b_data = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    got_v.delete(); got_c.delete(); exp_v.delete(); exp_c.delete();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    clear_q();
    m_row = 0;
    m_col = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'($urandom);
      r_data = 8'($urandom); g_data = 8'($urandom); b_data = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if (dout_valid !== 1'b0 || proc_data !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got v=%b d=%0h want v=0 d=0", i, dout_valid, proc_data);
      end
    end
    clear_q();
    m_row = 0; m_col = 0;
    rst_n = 1'b1;
    put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(8);
    total++;
    if (got_v.size() != 0) begin
      bad++;
      $display("FAIL reset_first_px outputs=%0d want 0", got_v.size());
    end
  endtask

  task automatic test_black_white();
    int n0, n63, n191, n255;
    img_width = 12'd640;
    apply_reset(3);
    for (int l = 0; l < 7; l++) begin
      for (int c = 0; c < 640; c++) put_px(0, 0, 0);
      idle(2);
    end
    idle(10);
    total++;
    if (got_v.size() != exp_v.size()) begin
      bad++; $display("FAIL black count got=%0d want=%0d", got_v.size(), exp_v.size());
    end
    n0 = 0;
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      if (got_v[i] === 8'd0) n0++;
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL black out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    total++;
    if (n0 != 5 * 638) begin bad++; $display("FAIL black zeros got=%0d want=%0d", n0, 5 * 638); end
    clear_q();

    for (int l = 0; l < 7; l++) begin
      for (int c = 0; c < 640; c++) put_px(255, 255, 255);
      idle(2);
    end
    idle(10);
    total++;
    if (got_v.size() != exp_v.size()) begin
      bad++; $display("FAIL white count got=%0d want=%0d", got_v.size(), exp_v.size());
    end
    n63 = 0; n191 = 0; n255 = 0;
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      if (got_v[i] === 8'd63)  n63++;
      if (got_v[i] === 8'd191) n191++;
      if (got_v[i] === 8'd255) n255++;
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL white out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    total++;
    if (n63 != 638 || n191 != 638 || n255 != 5 * 638) begin
      bad++;
      $display("FAIL white levels got 63:%0d 191:%0d 255:%0d want 638 638 3190", n63, n191, n255);
    end
    clear_q();
  endtask

  task automatic test_gray();
    int rgb[3][3];
    int want[3];
    rgb = '{'{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255}};
    want = '{76, 149, 28};
    img_width = 12'd16;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 32; c++) put_px(rgb[k][0], rgb[k][1], rgb[k][2]);
      idle(10);
      clear_q();
      for (int c = 0; c < 16; c++) put_px(rgb[k][0], rgb[k][1], rgb[k][2]);
      idle(10);
      total++;
      if (got_v.size() != 14 || exp_v.size() != 14) begin
        bad++; $display("FAIL gray%0d count got=%0d want=14", k, got_v.size());
      end
      for (int i = 0; i < got_v.size() && i < exp_c.size(); i++) begin
        total++;
        if (got_v[i] !== 8'(want[k]) || got_c[i] != exp_c[i]) begin
          bad++;
          $display("FAIL gray%0d out[%0d] got %0d@%0d want %0d@%0d", k, i, got_v[i], got_c[i], want[k], exp_c[i]);
        end
      end
      clear_q();
    end
  endtask

  task automatic test_random();
    img_width = 12'd640;
    apply_reset(3);
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < 640; c++)
        put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      idle(20);
    end
    idle(10);
    total++;
    if (got_v.size() != 8 * 638 || exp_v.size() != 8 * 638) begin
      bad++; $display("FAIL random count got=%0d want=%0d", got_v.size(), 8 * 638);
    end
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL random out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_gaps();
    int pr[185], pg[185], pb[185];
    logic [7:0] run_a[$];
    img_width = 12'd37;
    for (int i = 0; i < 185; i++) begin
      pr[i] = $urandom_range(0, 255); pg[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255);
    end
    apply_reset(3);
    for (int i = 0; i < 185; i++) put_px(pr[i], pg[i], pb[i]);
    idle(10);
    total++;
    if (got_v.size() != 3 * 35 || exp_v.size() != 3 * 35) begin
      bad++; $display("FAIL gaps_ref count got=%0d want=%0d", got_v.size(), 3 * 35);
    end
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL gaps_ref out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    run_a = exp_v;
    apply_reset(3);
    for (int i = 0; i < 185; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
      put_px(pr[i], pg[i], pb[i]);
    end
    idle(10);
    total++;
    if (got_v.size() != run_a.size()) begin
      bad++; $display("FAIL gaps_bubbled count got=%0d want=%0d", got_v.size(), run_a.size());
    end
    for (int i = 0; i < got_v.size() && i < run_a.size() && i < exp_c.size(); i++) begin
      total++;
      if (got_v[i] !== run_a[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL gaps_bubbled out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], run_a[i], exp_c[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_reset_midline();
    int line3_start;
    img_width = 12'd20;
    apply_reset(3);
    for (int i = 0; i < 50; i++)
      put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    total++;
    if (dout_valid !== 1'b1) begin
      bad++; $display("FAIL midline_active got v=%b want v=1", dout_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (dout_valid !== 1'b0 || proc_data !== 8'd0) begin
      bad++; $display("FAIL midline_clear got v=%b d=%0h want v=0 d=0", dout_valid, proc_data);
    end
    @(posedge clk); #1;
    apply_reset(2);
    for (int i = 0; i < 40; i++)
      put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    line3_start = cyc;
    for (int i = 0; i < 20; i++)
      put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(10);
    total++;
    if (got_v.size() != 18 || exp_v.size() != 18) begin
      bad++; $display("FAIL midline_resume count got=%0d want=18", got_v.size());
    end
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i] || got_c[i] <= line3_start) begin
        bad++;
        $display("FAIL midline_resume out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_narrow();
    img_width = 12'd2;
    apply_reset(3);
    for (int i = 0; i < 16; i++) put_px(255, 255, 255);
    idle(10);
    total++;
    if (got_v.size() != 0) begin
      bad++; $display("FAIL narrow_w2 outputs got=%0d want=0", got_v.size());
    end
    img_width = 12'd3;
    apply_reset(3);
    for (int i = 0; i < 15; i++)
      put_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(10);
    total++;
    if (got_v.size() != 3 || exp_v.size() != 3) begin
      bad++; $display("FAIL narrow_w3 count got=%0d want=3", got_v.size());
    end
    for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
      total++;
      if (got_v[i] !== exp_v[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL narrow_w3 out[%0d] got %0h@%0d want %0h@%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
      end
    end
    clear_q();
  endtask

  initial begin
    #1;
    test_reset();
    test_black_white();
    test_gray();
    test_random();
    test_gaps();
    test_reset_midline();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
